rf_wb_queue: RTL and testbench
==============================

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of pending write-back entries (fixed at 4; other values are out of scope).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  producer presents a write-back request.
REQ-005 in_regsel  input  3  destination register index of the request.
REQ-006 in_data  input  16  data to be written.
REQ-007 in_ready  output  1  queue can accept a request this cycle.
REQ-008 drain_en  input  1  register file write port available this cycle.
REQ-009 writeregsel  output  3  register index driven to the register file write port.
REQ-010 writedata  output  16  data driven to the register file write port.
REQ-011 write  output  1  write strobe to the register file.
REQ-012 probe1regsel, probe2regsel  input  3 each  register indices being read by the consumer.
REQ-013 pend1, pend2  output  1 each  a queued entry targets the matching probe index.
REQ-014 fwd1data, fwd2data  output  16 each  data of the youngest queued entry matching the probe.
REQ-015 count  output  3  number of valid entries, 0..4.
REQ-016 err  output  1  overflow indication.

Function
REQ-017 The queue SHALL be a 4-entry circular FIFO of {regsel[2:0], data[15:0]} with 2-bit head/tail pointers that wrap 3->0, plus a 3-bit occupancy count.
REQ-018 in_ready SHALL equal (count != 4), independent of same-cycle drain.
REQ-019 Push: on a rising edge with in_valid & in_ready, the request SHALL be written at tail, tail incremented.
REQ-020 write SHALL equal (count != 0) & drain_en, combinationally; writeregsel/writedata SHALL equal the head entry, and SHALL be 0 when count == 0.
REQ-021 Pop: on a rising edge with write == 1, head SHALL increment.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push-only increments, pop-only decrements.
REQ-023 A request pushed into an empty queue SHALL NOT bypass; earliest write for it is the next cycle (latency 1).
REQ-024 Entries SHALL drain strictly in push order; duplicate regsel entries are permitted and all written.
REQ-025 pendN SHALL be 1 iff any valid entry (head included, even if popping this cycle) has regsel == probeNregsel; combinational.
REQ-026 fwdNdata SHALL be the data of the youngest (closest to tail) matching valid entry; 0 when pendN == 0.
REQ-027 err SHALL be a registered one-cycle pulse, set on the edge after a cycle with in_valid & !in_ready; the dropped request SHALL NOT alter queue state.
REQ-028 State SHALL never change when in_valid == 0 and write == 0.

Reset
REQ-029 While rst is high at a rising edge, head, tail and count SHALL become 0 and err SHALL become 0; entry storage contents need not be cleared.
REQ-030 After reset: in_ready = 1, write = 0, writeregsel = 0, writedata = 0, pend1 = pend2 = 0, fwd1data = fwd2data = 0, count = 0.
REQ-031 Reset SHALL take priority over simultaneous push, pop, or overflow; any queued writes are discarded.

Verification
REQ-032 Push r3=0x1234 with drain_en=1 -> next cycle write=1, writeregsel=3, writedata=0x1234; following cycle count=0, write=0.
REQ-033 drain_en=0, push r1=0x0001, r2=0x0002, r1=0x0003 -> count=3; probe1regsel=1 -> pend1=1, fwd1data=0x0003; probe2regsel=5 -> pend2=0, fwd2data=0.
REQ-034 drain_en=0, push 5 requests -> count=4, in_ready=0 after fourth; fifth -> err=1 for exactly one cycle, count stays 4; then drain_en=1 -> first four drained in order, fifth never written.
REQ-035 At count=4 with drain_en=1 and in_valid=1 -> request rejected (in_ready=0), err pulses, count becomes 3.
REQ-036 Fill 3 entries, drain 3, push 3 more with drain_en=1 continuously -> pointers wrap 3->0, writes emerge in push order, count returns to 0.
REQ-037 Assert rst while count=2 and in_valid=1 -> next cycle count=0, write=0, pend1=pend2=0, err=0.

Source files
------------

// File: rtl/rf_wb_queue.sv
// Register-file write-back queue: 4-entry FIFO between producer and RF write port,
// with pending/forwarding lookup for two read probes.
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  in_regsel,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        drain_en,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic        write,
    input  logic [2:0]  probe1regsel,
    input  logic [2:0]  probe2regsel,
    output logic        pend1,
    output logic        pend2,
    output logic [15:0] fwd1data,
    output logic [15:0] fwd2data,
    output logic [2:0]  count,
    output logic        err
);

    localparam logic [2:0] FULL = 3'(DEPTH);

    logic [2:0]  regsel_q [DEPTH];
    logic [15:0] data_q   [DEPTH];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  count_q;
    logic        err_q;
    logic        push;
    logic        pop;

    assign in_ready    = (count_q != FULL);
    assign push        = in_valid & in_ready;
    assign write       = (count_q != 3'd0) & drain_en;
    assign pop         = write;
    assign count       = count_q;
    assign err         = err_q;
    assign writeregsel = (count_q != 3'd0) ? regsel_q[head] : 3'd0;
    assign writedata   = (count_q != 3'd0) ? data_q[head] : 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= 2'd0;
            tail    <= 2'd0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            if (push) tail <= tail + 2'd1;
            if (pop)  head <= head + 2'd1;
            count_q <= count_q + 3'(push) - 3'(pop);
            err_q   <= in_valid & ~in_ready;
        end
    end

    // Storage is left uncleared by reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            regsel_q[tail] <= in_regsel;
            data_q[tail]   <= in_data;
        end
    end

    // Walk oldest to youngest so the last match is the youngest entry.
    always_comb begin
        logic [1:0] idx;
        idx      = head;
        pend1    = 1'b0;
        pend2    = 1'b0;
        fwd1data = 16'd0;
        fwd2data = 16'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + 2'(i);
            if (3'(i) < count_q) begin
                if (regsel_q[idx] == probe1regsel) begin
                    pend1    = 1'b1;
                    fwd1data = data_q[idx];
                end
                if (regsel_q[idx] == probe2regsel) begin
                    pend2    = 1'b1;
                    fwd2data = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed vector table, then a scoreboarded
// wrap sequence and a randomized run against a queue model.
module tb_rf_wb_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_regsel;
    logic [15:0] in_data;
    logic        in_ready;
    logic        drain_en;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic        write;
    logic [2:0]  probe1regsel;
    logic [2:0]  probe2regsel;
    logic        pend1;
    logic        pend2;
    logic [15:0] fwd1data;
    logic [15:0] fwd2data;
    logic [2:0]  count;
    logic        err;

    int tests = 0;
    int fails = 0;

    rf_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_regsel(in_regsel), .in_data(in_data),
        .in_ready(in_ready), .drain_en(drain_en),
        .writeregsel(writeregsel), .writedata(writedata), .write(write),
        .probe1regsel(probe1regsel), .probe2regsel(probe2regsel),
        .pend1(pend1), .pend2(pend2),
        .fwd1data(fwd1data), .fwd2data(fwd2data),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, vld;
        logic [2:0]  rs;
        logic [15:0] d;
        logic        de;
        logic [2:0]  p1, p2;
        logic        e_rdy, e_wr;
        logic [2:0]  e_ws;
        logic [15:0] e_wd;
        logic        e_pd1, e_pd2;
        logic [15:0] e_f1, e_f2;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [2:0]  rs;
        logic [15:0] d;
    } ent_t;

    vec_t tbl[64];
    int   n = 0;
    ent_t mq[$];
    logic err_exp = 1'b0;

    function automatic vec_t mk(int r, int v, int rs, int d, int de, int p1, int p2,
                                int rdy, int wr, int ws, int wd, int pd1, int pd2,
                                int f1, int f2, int c, int e);
        vec_t m;
        m.rst = r[0]; m.vld = v[0]; m.rs = rs[2:0]; m.d = d[15:0];
        m.de = de[0]; m.p1 = p1[2:0]; m.p2 = p2[2:0];
        m.e_rdy = rdy[0]; m.e_wr = wr[0]; m.e_ws = ws[2:0]; m.e_wd = wd[15:0];
        m.e_pd1 = pd1[0]; m.e_pd2 = pd2[0]; m.e_f1 = f1[15:0]; m.e_f2 = f2[15:0];
        m.e_cnt = c[2:0]; m.e_err = e[0];
        return m;
    endfunction

    task automatic chk(input string nm, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] rs,
                         input logic [15:0] d, input logic de,
                         input logic [2:0] p1, input logic [2:0] p2);
        @(negedge clk);
        rst = r; in_valid = v; in_regsel = rs; in_data = d;
        drain_en = de; probe1regsel = p1; probe2regsel = p2;
        #1;
    endtask

    task automatic sb_cycle(input int k, input logic v, input logic [2:0] rs,
                            input logic [15:0] d, input logic de,
                            input logic [2:0] p1, input logic [2:0] p2);
        int          sz;
        logic        wr_e, pd1_e, pd2_e;
        logic [2:0]  ws_e;
        logic [15:0] wd_e, f1_e, f2_e;
        ent_t        e;
        drive(1'b0, v, rs, d, de, p1, p2);
        sz    = mq.size();
        wr_e  = (sz != 0) && de;
        ws_e  = 3'd0; wd_e = 16'd0;
        pd1_e = 1'b0; pd2_e = 1'b0; f1_e = 16'd0; f2_e = 16'd0;
        for (int i = 0; i < sz; i++) begin
            if (mq[i].rs == p1) begin pd1_e = 1'b1; f1_e = mq[i].d; end
            if (mq[i].rs == p2) begin pd2_e = 1'b1; f2_e = mq[i].d; end
        end
        chk("sb_count", k, 16'(count), 16'(sz));
        chk("sb_ready", k, 16'(in_ready), 16'(sz != 4));
        chk("sb_err", k, 16'(err), 16'(err_exp));
        chk("sb_write", k, 16'(write), 16'(wr_e));
        chk("sb_pend1", k, 16'(pend1), 16'(pd1_e));
        chk("sb_fwd1", k, fwd1data, f1_e);
        chk("sb_pend2", k, 16'(pend2), 16'(pd2_e));
        chk("sb_fwd2", k, fwd2data, f2_e);
        if (sz != 0) begin
            ws_e = mq[0].rs;
            wd_e = mq[0].d;
        end
        chk("sb_wsel", k, 16'(writeregsel), 16'(ws_e));
        chk("sb_wdata", k, writedata, wd_e);
        if (wr_e) e = mq.pop_front();
        if (v && sz != 4) begin
            e.rs = rs; e.d = d;
            mq.push_back(e);
        end
        err_exp = v && (sz == 4);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_regsel = 3'd0; in_data = 16'd0;
        drain_en = 1'b0; probe1regsel = 3'd0; probe2regsel = 3'd0;
        repeat (2) @(posedge clk);

        // idle after reset
        tbl[n++] = mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
        // single push with drain: latency one, then empty
        tbl[n++] = mk(0,1,3,'h1234,1,3,0, 1,0,0,0,0,0,0,0,0,0);
        tbl[n++] = mk(0,0,0,0,1,3,0, 1,1,3,'h1234,1,0,'h1234,0,1,0);
        tbl[n++] = mk(0,0,0,0,1,3,0, 1,0,0,0,0,0,0,0,0,0);
        // duplicate regsel forwarding, youngest wins
        tbl[n++] = mk(0,1,1,1,0,1,5, 1,0,0,0,0,0,0,0,0,0);
        tbl[n++] = mk(0,1,2,2,0,1,5, 1,0,1,1,1,0,1,0,1,0);
        tbl[n++] = mk(0,1,1,3,0,1,5, 1,0,1,1,1,0,1,0,2,0);
        tbl[n++] = mk(0,0,0,0,0,1,5, 1,0,1,1,1,0,3,0,3,0);
        tbl[n++] = mk(0,0,0,0,0,2,1, 1,0,1,1,1,1,2,3,3,0);
        tbl[n++] = mk(0,0,0,0,1,0,0, 1,1,1,1,0,0,0,0,3,0);
        tbl[n++] = mk(0,0,0,0,1,0,0, 1,1,2,2,0,0,0,0,2,0);
        tbl[n++] = mk(0,0,0,0,1,0,0, 1,1,1,3,0,0,0,0,1,0);
        tbl[n++] = mk(0,0,0,0,1,0,0, 1,0,0,0,0,0,0,0,0,0);
        // overflow: fifth push dropped, err one cycle
        tbl[n++] = mk(0,1,4,'h0a04,0,0,4, 1,0,0,0,0,0,0,0,0,0);
        tbl[n++] = mk(0,1,5,'h0b05,0,0,4, 1,0,4,'h0a04,0,1,0,'h0a04,1,0);
        tbl[n++] = mk(0,1,6,'h0c06,0,0,4, 1,0,4,'h0a04,0,1,0,'h0a04,2,0);
        tbl[n++] = mk(0,1,7,'h0d07,0,0,4, 1,0,4,'h0a04,0,1,0,'h0a04,3,0);
        tbl[n++] = mk(0,1,0,'h0e00,0,0,4, 0,0,4,'h0a04,0,1,0,'h0a04,4,0);
        tbl[n++] = mk(0,0,0,0,0,0,4, 0,0,4,'h0a04,0,1,0,'h0a04,4,1);
        tbl[n++] = mk(0,0,0,0,0,0,4, 0,0,4,'h0a04,0,1,0,'h0a04,4,0);
        tbl[n++] = mk(0,0,0,0,1,0,4, 0,1,4,'h0a04,0,1,0,'h0a04,4,0);
        tbl[n++] = mk(0,0,0,0,1,0,4, 1,1,5,'h0b05,0,0,0,0,3,0);
        tbl[n++] = mk(0,0,0,0,1,0,4, 1,1,6,'h0c06,0,0,0,0,2,0);
        tbl[n++] = mk(0,0,0,0,1,0,4, 1,1,7,'h0d07,0,0,0,0,1,0);
        tbl[n++] = mk(0,0,0,0,1,0,4, 1,0,0,0,0,0,0,0,0,0);
        // full with drain and push: rejected, count drops to 3
        tbl[n++] = mk(0,1,1,'h0101,0,0,0, 1,0,0,0,0,0,0,0,0,0);
        tbl[n++] = mk(0,1,2,'h0202,0,0,0, 1,0,1,'h0101,0,0,0,0,1,0);
        tbl[n++] = mk(0,1,3,'h0303,0,0,0, 1,0,1,'h0101,0,0,0,0,2,0);
        tbl[n++] = mk(0,1,4,'h0404,0,0,0, 1,0,1,'h0101,0,0,0,0,3,0);
        tbl[n++] = mk(0,1,5,'h0505,1,0,0, 0,1,1,'h0101,0,0,0,0,4,0);
        tbl[n++] = mk(0,0,0,0,0,0,0, 1,0,2,'h0202,0,0,0,0,3,1);
        tbl[n++] = mk(0,0,0,0,0,0,0, 1,0,2,'h0202,0,0,0,0,3,0);
        // reset at count 2 with a push and drain pending
        tbl[n++] = mk(0,0,0,0,1,3,4, 1,1,2,'h0202,1,1,'h0303,'h0404,3,0);
        tbl[n++] = mk(1,1,6,'h0606,1,3,4, 1,1,3,'h0303,1,1,'h0303,'h0404,2,0);
        tbl[n++] = mk(0,0,0,0,1,3,4, 1,0,0,0,0,0,0,0,0,0);

        for (int k = 0; k < n; k++) begin
            drive(tbl[k].rst, tbl[k].vld, tbl[k].rs, tbl[k].d,
                  tbl[k].de, tbl[k].p1, tbl[k].p2);
            chk("ready", k, 16'(in_ready), 16'(tbl[k].e_rdy));
            chk("write", k, 16'(write), 16'(tbl[k].e_wr));
            chk("wsel", k, 16'(writeregsel), 16'(tbl[k].e_ws));
            chk("wdata", k, writedata, tbl[k].e_wd);
            chk("pend1", k, 16'(pend1), 16'(tbl[k].e_pd1));
            chk("pend2", k, 16'(pend2), 16'(tbl[k].e_pd2));
            chk("fwd1", k, fwd1data, tbl[k].e_f1);
            chk("fwd2", k, fwd2data, tbl[k].e_f2);
            chk("count", k, 16'(count), 16'(tbl[k].e_cnt));
            chk("err", k, 16'(err), 16'(tbl[k].e_err));
        end

        // pointer wrap: fill 3, drain 3, push 3 with continuous drain
        for (int i = 0; i < 3; i++)
            sb_cycle(100 + i, 1'b1, 3'(i + 1), 16'(16'h1100 + i), 1'b0, 3'd1, 3'd2);
        for (int i = 0; i < 3; i++)
            sb_cycle(110 + i, 1'b0, 3'd0, 16'd0, 1'b1, 3'd1, 3'd2);
        for (int i = 0; i < 3; i++)
            sb_cycle(120 + i, 1'b1, 3'(i + 5), 16'(16'h2200 + i), 1'b1, 3'd5, 3'd7);
        for (int i = 0; i < 3; i++)
            sb_cycle(130 + i, 1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 3'd7);

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++)
            sb_cycle(200 + i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     16'($urandom), 1'($urandom_range(0, 2) == 0),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++)
            sb_cycle(700 + i, 1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
